// File: rtl/token_buffer_mc_pkg.sv
// Shared token types, channel-array types, pointer type and block FSM state codes
// for token_buffer_mc and its per-channel sub-module.
package token_buffer_mc_pkg;

    localparam int NUM_CH_DEF = 2;
    localparam int DEPTH_DEF  = 16;
    localparam int WIDTH_DATA = 32;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  c;
        logic                  r;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    // Stored payload: the valid bit is implied by the slot being inside the window.
    typedef struct packed {
        logic                  a;
        logic                  c;
        logic                  r;
        logic [WIDTH_DATA-1:0] d;
    } entry_t;

    typedef FTk_t [NUM_CH_DEF-1:0] FTk_ch_t;
    typedef BTk_t [NUM_CH_DEF-1:0] BTk_ch_t;
    typedef logic [$clog2(DEPTH_DEF):0] ptr_t;

    // fsm_token
    localparam logic [1:0] eMPTY  = 2'd0;
    localparam logic [1:0] fILL   = 2'd1;
    localparam logic [1:0] wAIT   = 2'd2;
    localparam logic [1:0] rEVERT = 2'd3;

endpackage

// File: rtl/token_buffer_ch.sv
// One channel of token_buffer_mc: storage, wptr/rptr/mark pointers and the block FSM.
// Block replay (revert) exists only when TOKEN_BUFFER_REVERT_EN is defined.
module token_buffer_ch
    import token_buffer_mc_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  FTk_t i_ftk,
    output BTk_t o_btk,
    output FTk_t o_ftk,
    input  BTk_t i_btk
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

    entry_t      mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] mark_q, mark_d;
    logic [1:0]  state_q, state_d;
    logic        commit_q, commit_d;

    logic [AW:0] held;
    logic [AW:0] readable;
    logic        nack;
    logic        out_v;
    logic        push;
    logic        pop;
    entry_t      head;

    always_comb begin
        held     = wptr_q - mark_q;
        readable = wptr_q - rptr_q;
        // Held low during reset so upstream never sees backpressure from a cleared channel.
        nack     = rst_n & ((held == DEPTH_P) | i_btk.t);
        head     = mem_q[rptr_q[AW-1:0]];
        out_v    = (readable != '0) && ((state_q == eMPTY) || (state_q == fILL));
        push     = i_ftk.v & ~nack;
        pop      = out_v & ~i_btk.n;

        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
        mark_d   = mark_q;
        state_d  = state_q;
        commit_d = 1'b0;

        case (state_q)
            eMPTY, fILL: begin
                // A release popped from eMPTY still closes its block.
                if (pop && head.r) state_d = wAIT;
                else               state_d = (wptr_d != rptr_d) ? fILL : eMPTY;
            end
            wAIT: begin
                if (i_btk.v) begin
`ifdef TOKEN_BUFFER_REVERT_EN
                    if (i_btk.c) begin
                        commit_d = 1'b1;
                        mark_d   = rptr_q;
                        state_d  = (wptr_d != rptr_d) ? fILL : eMPTY;
                    end else begin
                        state_d  = rEVERT;
                    end
`else
                    commit_d = 1'b1;
                    state_d  = (wptr_d != rptr_d) ? fILL : eMPTY;
`endif
                end
            end
            rEVERT: begin
                rptr_d  = mark_q;
                state_d = fILL;
            end
            default: state_d = eMPTY;
        endcase

`ifndef TOKEN_BUFFER_REVERT_EN
        mark_d = rptr_d;
`endif

        if (i_btk.t) begin
            wptr_d   = '0;
            rptr_d   = '0;
            mark_d   = '0;
            state_d  = eMPTY;
            commit_d = 1'b0;
        end
    end

`ifndef TOKEN_BUFFER_REVERT_EN
    logic unused_c;
    assign unused_c = i_btk.c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            mark_q   <= '0;
            state_q  <= eMPTY;
            commit_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            mark_q   <= mark_d;
            state_q  <= state_d;
            commit_q <= commit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= '{a: i_ftk.a, c: i_ftk.c, r: i_ftk.r, d: i_ftk.d};
        end
    end

    always_comb begin
        o_ftk = '0;
        if (out_v) o_ftk = '{v: 1'b1, a: head.a, c: head.c, r: head.r, d: head.d};
        o_btk = '{n: nack, t: i_btk.t, v: commit_q, c: commit_q};
    end

endmodule

// File: rtl/token_buffer_mc.sv
// Multi-channel forward-token buffer: NUM_CH independent token_buffer_ch instances.
// Define TOKEN_BUFFER_REVERT_EN to hold blocks until commit and allow replay.
module token_buffer_mc
    import token_buffer_mc_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  FTk_t [NUM_CH-1:0] I_FTk,
    output BTk_t [NUM_CH-1:0] O_BTk,
    output FTk_t [NUM_CH-1:0] O_FTk,
    input  BTk_t [NUM_CH-1:0] I_BTk
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            token_buffer_ch #(
                .DEPTH (DEPTH)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .i_ftk (I_FTk[gi]),
                .o_btk (O_BTk[gi]),
                .o_ftk (O_FTk[gi]),
                .i_btk (I_BTk[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_token_buffer_mc.sv
// Bench for token_buffer_mc: directed scenarios plus random traffic, all checked
// against a queue-based model of each channel's held block.
module tb_token_buffer_mc;
    import token_buffer_mc_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int P_RUN  = 0;
    localparam int P_WAIT = 1;
    localparam int P_REV  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    FTk_t [NUM_CH-1:0] i_ftk;
    FTk_t [NUM_CH-1:0] o_ftk;
    BTk_t [NUM_CH-1:0] i_btk;
    BTk_t [NUM_CH-1:0] o_btk;

    int checks = 0;
    int errors = 0;

    // Model: mq holds every entry not yet freed; rd is how many of them were sent.
    entry_t mq [NUM_CH][$];
    int     rd [NUM_CH];
    int     ph [NUM_CH];
    bit     cp [NUM_CH];

    token_buffer_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I_FTk (i_ftk),
        .O_BTk (o_btk),
        .O_FTk (o_ftk),
        .I_BTk (i_btk)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic FTk_t mk(input bit r, input logic [31:0] d);
        return '{v: 1'b1, a: 1'b0, c: 1'b0, r: r, d: d};
    endfunction

    function automatic FTk_t exp_ftk(input int ch);
        FTk_t   f;
        entry_t e;
        f = '0;
        if (ph[ch] == P_RUN && mq[ch].size() > rd[ch]) begin
            e = mq[ch][rd[ch]];
            f = '{v: 1'b1, a: e.a, c: e.c, r: e.r, d: e.d};
        end
        return f;
    endfunction

    function automatic BTk_t exp_btk(input int ch);
        BTk_t b;
        b.n = (mq[ch].size() == DEPTH) || i_btk[ch].t;
        b.t = i_btk[ch].t;
        b.v = cp[ch];
        b.c = cp[ch];
        return b;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mq[ch].delete();
            rd[ch] = 0;
            ph[ch] = P_RUN;
            cp[ch] = 1'b0;
        end
    endtask

    task automatic model_edge(input int ch);
        FTk_t o;
        BTk_t b;
        bit   push;
        bit   pop;
        o    = exp_ftk(ch);
        b    = exp_btk(ch);
        push = i_ftk[ch].v && !b.n;
        pop  = o.v && !i_btk[ch].n;
        cp[ch] = 1'b0;
        if (i_btk[ch].t) begin
            mq[ch].delete();
            rd[ch] = 0;
            ph[ch] = P_RUN;
        end else begin
            case (ph[ch])
                P_RUN: if (pop) begin
`ifdef TOKEN_BUFFER_REVERT_EN
                    rd[ch]++;
`else
                    void'(mq[ch].pop_front());
`endif
                    if (o.r) ph[ch] = P_WAIT;
                end
                P_WAIT: if (i_btk[ch].v) begin
`ifdef TOKEN_BUFFER_REVERT_EN
                    if (i_btk[ch].c) begin
                        repeat (rd[ch]) void'(mq[ch].pop_front());
                        rd[ch] = 0;
                        cp[ch] = 1'b1;
                        ph[ch] = P_RUN;
                    end else begin
                        ph[ch] = P_REV;
                    end
`else
                    cp[ch] = 1'b1;
                    ph[ch] = P_RUN;
`endif
                end
                default: begin
                    rd[ch] = 0;
                    ph[ch] = P_RUN;
                end
            endcase
            if (push) mq[ch].push_back('{a: i_ftk[ch].a, c: i_ftk[ch].c, r: i_ftk[ch].r, d: i_ftk[ch].d});
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("%s.ftk%0d", tag, ch), 64'(o_ftk[ch]), 64'(exp_ftk(ch)));
            check($sformatf("%s.btk%0d", tag, ch), 64'(o_btk[ch]), 64'(exp_btk(ch)));
        end
        $display("%0t %s ch0 ftk=%h btk=%h ch1 ftk=%h btk=%h", $time, tag,
                 o_ftk[0], o_btk[0], o_ftk[1], o_btk[1]);
        for (int ch = 0; ch < NUM_CH; ch++) model_edge(ch);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush();
        i_ftk = '0;
        for (int ch = 0; ch < NUM_CH; ch++) i_btk[ch] = '{n: 1'b0, t: 1'b1, v: 1'b0, c: 1'b0};
        cycle("flush");
        i_btk = '0;
    endtask

    initial begin
        logic [31:0] got1 [$];
        bit          pending;
        bit          acc;

        rst_n = 1'b0;
        i_ftk = '0;
        i_btk = '0;
        model_reset();
        @(negedge clk);
        cycle("rst");
        cycle("rst");
        rst_n = 1'b1;
        cycle("idle");

        // Block of five, released on the last.
        for (int k = 1; k <= 5; k++) begin
            i_ftk[0] = mk(k == 5, 32'(k));
            cycle("blk");
        end
        i_ftk[0] = '0;
        for (int k = 0; k < 7; k++) cycle("stream");
        #1;
        check("wait_v", 64'(o_ftk[0].v), 64'd0);

        // Reject, replay, then commit.
        i_btk[0] = '{n: 1'b0, t: 1'b0, v: 1'b1, c: 1'b0};
        cycle("rvt");
        i_btk[0] = '0;
        for (int k = 0; k < 8; k++) cycle("replay");
        i_btk[0] = '{n: 1'b0, t: 1'b0, v: 1'b1, c: 1'b1};
        cycle("cmt");
        i_btk[0] = '0;
`ifdef TOKEN_BUFFER_REVERT_EN
        #1;
        check("cmt_pulse_v", 64'(o_btk[0].v), 64'd1);
        check("cmt_pulse_c", 64'(o_btk[0].c), 64'd1);
`endif
        cycle("cmt_after");
        cycle("cmt_after");

        // Fill to DEPTH with downstream stalled; 17th token waits upstream.
        flush();
        i_btk[0].n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_ftk[0] = mk(k == 15, 32'h100 + 32'(k));
            if (k == 15) begin
                #1;
                check("pre_full_n", 64'(o_btk[0].n), 64'd0);
            end
            cycle("fill");
        end
        i_ftk[0] = mk(1'b0, 32'h1FF);
        #1;
        check("full_n", 64'(o_btk[0].n), 64'd1);
        cycle("full");
        cycle("full");
        i_btk[0].n = 1'b0;
        pending    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            i_btk[0].v = (ph[0] == P_WAIT);
            i_btk[0].c = 1'b1;
            acc = pending && !exp_btk(0).n;
            cycle("drain");
            if (acc) begin
                pending  = 1'b0;
                i_ftk[0] = '0;
            end
        end
        check("tok17_taken", 64'(pending), 64'd0);

        // Channel 0 stalled while channel 1 streams.
        flush();
        i_btk[0].n = 1'b1;
        got1.delete();
        for (int k = 0; k < 4; k++) begin
            i_ftk[0] = mk(1'b0, 32'h200 + 32'(k));
            i_ftk[1] = mk(k == 3, 32'hA + 32'(k));
            #1;
            if (o_ftk[1].v) got1.push_back(o_ftk[1].d);
            cycle("stall");
        end
        i_ftk = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_ftk[1].v) got1.push_back(o_ftk[1].d);
            cycle("stall_run");
        end
        check("ch1_count", 64'(got1.size()), 64'd4);
        for (int k = 0; k < got1.size() && k < 4; k++)
            check($sformatf("ch1_d%0d", k), 64'(got1[k]), 64'hA + 64'(k));
        #1;
        check("ch0_hold_v", 64'(o_ftk[0].v), 64'd1);
        check("ch0_hold_d", 64'(o_ftk[0].d), 64'h200);
        i_btk[0].n = 1'b0;
        for (int k = 0; k < 6; k++) cycle("unstall");

        // Terminate with seven held and a push pending.
        flush();
        i_btk[0].n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_ftk[0] = mk(1'b0, 32'h300 + 32'(k));
            cycle("t_fill");
        end
        i_ftk[0]   = mk(1'b0, 32'h3FF);
        i_btk[0].t = 1'b1;
        #1;
        check("term_n", 64'(o_btk[0].n), 64'd1);
        check("term_t", 64'(o_btk[0].t), 64'd1);
        cycle("term");
        i_ftk = '0;
        i_btk = '0;
        #1;
        check("term_empty_v", 64'(o_ftk[0].v), 64'd0);
        check("term_empty_n", 64'(o_btk[0].n), 64'd0);
        cycle("term_after");

        // Reset mid-stream.
        i_ftk[0] = mk(1'b0, 32'h400);
        i_ftk[1] = mk(1'b0, 32'h401);
        for (int k = 0; k < 3; k++) cycle("pre_rst");
        #1;
        rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("rst_ftk%0d", ch), 64'(o_ftk[ch]), 64'd0);
            check($sformatf("rst_btk%0d", ch), 64'(o_btk[ch]), 64'd0);
        end
        i_ftk = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        i_ftk[0] = mk(1'b0, 32'h55);
        cycle("p55");
        i_ftk[0] = '0;
        #1;
        check("p55_v", 64'(o_ftk[0].v), 64'd1);
        check("p55_d", 64'(o_ftk[0].d), 64'h55);
        cycle("p55_out");

        // Random traffic.
        flush();
        for (int k = 0; k < 600; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                i_ftk[ch] = '{v: 1'($urandom % 2), a: 1'($urandom % 2), c: 1'($urandom % 2),
                              r: ($urandom % 5) == 0, d: $urandom};
                i_btk[ch] = '{n: ($urandom % 4) == 0, t: ($urandom % 60) == 0,
                              v: ($urandom % 3) == 0, c: 1'($urandom % 2)};
            end
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
